rename_regfile: RTL and testbench

- Parametrised architectural register file with per-register rename tags (Tomasulo-style) for the out-of-order core.
- Issue stage reads operand values/tags through NUM_RD read ports and marks the destination busy with its RoB tag.
- Commit writes the architectural value and releases the tag only if it still owns the register.
- Adds a same-cycle commit-to-read bypass and a flush that keeps architectural values.

---
 rtl/rename_regfile.sv | 97 +++++++++
 tb/tb_rename_regfile.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename tags and busy bits.
// Issue marks destinations busy; commit writes values and releases owned tags.
module rename_regfile #(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  parameter  int TAG_W  = 4,
  parameter  int NUM_RD = 2,
  localparam int RIDX_W = $clog2(NREG)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     rob_clear,
  input  logic                     issue_valid,
  input  logic [RIDX_W-1:0]        issue_reg,
  input  logic [TAG_W-1:0]         issue_tag,
  input  logic                     commit_valid,
  input  logic [RIDX_W-1:0]        commit_reg,
  input  logic [XLEN-1:0]          commit_val,
  input  logic [TAG_W-1:0]         commit_tag,
  input  logic [NUM_RD*RIDX_W-1:0] rd_idx,
  output logic [NUM_RD*XLEN-1:0]   rd_val,
  output logic [NUM_RD*TAG_W-1:0]  rd_tag,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [RIDX_W:0]          busy_cnt
);

  logic [XLEN-1:0]  val_q  [NREG];
  logic [TAG_W-1:0] tag_q  [NREG];
  logic             busy_q [NREG];
  logic [RIDX_W:0]  cnt_q, cnt_d;

  logic com_en, com_own, iss_en, inc, dec;

  assign com_en  = rdy_in && commit_valid && (commit_reg != '0);
  assign iss_en  = rdy_in && issue_valid && (issue_reg != '0);
  assign com_own = com_en && busy_q[commit_reg] && (tag_q[commit_reg] == commit_tag);

  // An owning commit and an issue to the same register leave the busy bit set.
  assign inc = iss_en && !busy_q[issue_reg];
  assign dec = com_own && !(iss_en && (issue_reg == commit_reg));

  always_comb begin
    cnt_d = cnt_q + {{RIDX_W{1'b0}}, inc} - {{RIDX_W{1'b0}}, dec};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int r = 0; r < NREG; r++) begin
        val_q[r]  <= '0;
        tag_q[r]  <= '0;
        busy_q[r] <= 1'b0;
      end
      cnt_q <= '0;
    end else begin
      if (com_en) val_q[commit_reg] <= commit_val;
      if (rob_clear) begin
        for (int r = 0; r < NREG; r++) begin
          tag_q[r]  <= '0;
          busy_q[r] <= 1'b0;
        end
        cnt_q <= '0;
      end else begin
        if (com_own) busy_q[commit_reg] <= 1'b0;
        // Issue is written last so it overrides a same-register commit.
        if (iss_en) begin
          tag_q[issue_reg]  <= issue_tag;
          busy_q[issue_reg] <= 1'b1;
        end
        cnt_q <= cnt_d;
      end
    end
  end

  always_comb begin
    logic [RIDX_W-1:0] ridx;
    rd_val  = '0;
    rd_tag  = '0;
    rd_busy = '0;
    ridx    = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      ridx = rd_idx[p*RIDX_W +: RIDX_W];
      if (ridx != '0) begin
        if (com_en && (commit_reg == ridx) && busy_q[ridx] && (tag_q[ridx] == commit_tag)) begin
          rd_val[p*XLEN +: XLEN] = commit_val;
        end else begin
          rd_val[p*XLEN +: XLEN]   = val_q[ridx];
          rd_tag[p*TAG_W +: TAG_W] = tag_q[ridx];
          rd_busy[p]               = busy_q[ridx];
        end
      end
    end
  end

  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_rename_regfile.sv
// Bench for rename_regfile: array-based reference model checked every cycle,
// plus directed literal expectations.
module tb_rename_regfile;
  localparam int XLEN = 32, NREG = 32, TAG_W = 4, NUM_RD = 2, RIDX_W = 5;

  logic clk = 1'b0;
  logic rst, rdy, rob_clear, issue_valid, commit_valid;
  logic [RIDX_W-1:0] issue_reg, commit_reg;
  logic [TAG_W-1:0] issue_tag, commit_tag;
  logic [XLEN-1:0] commit_val;
  logic [NUM_RD*RIDX_W-1:0] rd_idx;
  logic [NUM_RD*XLEN-1:0] rd_val;
  logic [NUM_RD*TAG_W-1:0] rd_tag;
  logic [NUM_RD-1:0] rd_busy;
  logic [RIDX_W:0] busy_cnt;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [XLEN-1:0]  m_val  [NREG];
  logic [TAG_W-1:0] m_tag  [NREG];
  logic             m_busy [NREG];

  always #5 clk = ~clk;

  rename_regfile #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NUM_RD(NUM_RD)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .rob_clear(rob_clear),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_tag(issue_tag),
    .commit_valid(commit_valid), .commit_reg(commit_reg), .commit_val(commit_val),
    .commit_tag(commit_tag), .rd_idx(rd_idx), .rd_val(rd_val), .rd_tag(rd_tag),
    .rd_busy(rd_busy), .busy_cnt(busy_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: register contents follow the update rules directly.
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_val[r] <= '0; m_tag[r] <= '0; m_busy[r] <= 1'b0;
      end
    end else begin
      if (rdy && commit_valid && commit_reg != 0) m_val[commit_reg] <= commit_val;
      if (rob_clear) begin
        for (int r = 0; r < NREG; r++) begin
          m_tag[r] <= '0; m_busy[r] <= 1'b0;
        end
      end else if (rdy) begin
        if (commit_valid && commit_reg != 0 && m_busy[commit_reg] && m_tag[commit_reg] == commit_tag)
          m_busy[commit_reg] <= 1'b0;
        if (issue_valid && issue_reg != 0) begin
          m_tag[issue_reg] <= issue_tag; m_busy[issue_reg] <= 1'b1;
        end
      end
    end
  end

  task automatic model_read(input int idx, output logic [XLEN-1:0] v,
                            output logic [TAG_W-1:0] t, output logic b);
    v = '0; t = '0; b = 1'b0;
    if (idx != 0) begin
      if (rdy && commit_valid && int'(commit_reg) == idx && m_busy[idx] && m_tag[idx] == commit_tag) begin
        v = commit_val;
      end else begin
        v = m_val[idx]; t = m_tag[idx]; b = m_busy[idx];
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [XLEN-1:0] ev; logic [TAG_W-1:0] et; logic eb; int pc;
      for (int p = 0; p < NUM_RD; p++) begin
        model_read(int'(rd_idx[p*RIDX_W +: RIDX_W]), ev, et, eb);
        chk($sformatf("model rd_val[%0d]", p), 64'(rd_val[p*XLEN +: XLEN]), 64'(ev));
        chk($sformatf("model rd_tag[%0d]", p), 64'(rd_tag[p*TAG_W +: TAG_W]), 64'(et));
        chk($sformatf("model rd_busy[%0d]", p), 64'(rd_busy[p]), 64'(eb));
      end
      pc = 0;
      for (int r = 0; r < NREG; r++) pc += int'(m_busy[r]);
      chk("model busy_cnt", 64'(busy_cnt), 64'(pc));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    rob_clear = 0; issue_valid = 0; commit_valid = 0;
    issue_reg = 0; issue_tag = 0; commit_reg = 0; commit_val = 0; commit_tag = 0;
  endtask

  task automatic rd(input int r0, input int r1);
    rd_idx = {RIDX_W'(r1), RIDX_W'(r0)};
  endtask

  task automatic issue(input int r, input int t);
    issue_valid = 1; issue_reg = RIDX_W'(r); issue_tag = TAG_W'(t);
  endtask

  task automatic commit(input int r, input int t, input logic [XLEN-1:0] v);
    commit_valid = 1; commit_reg = RIDX_W'(r); commit_tag = TAG_W'(t); commit_val = v;
  endtask

  function automatic logic [XLEN-1:0] rv(input int p);
    return rd_val[p*XLEN +: XLEN];
  endfunction

  function automatic logic [TAG_W-1:0] rt(input int p);
    return rd_tag[p*TAG_W +: TAG_W];
  endfunction

  initial begin
    rst = 1; rdy = 1; idle(); rd(0, 0);
    step(); step();
    rst = 0; chk_en = 1;

    rd(5, 0);
    sample();
    chk("reset x5 val", 64'(rv(0)), 64'h0);
    chk("reset x5 busy", 64'(rd_busy[0]), 64'h0);
    chk("reset x0 val", 64'(rv(1)), 64'h0);
    chk("reset cnt", 64'(busy_cnt), 64'h0);

    step(); issue(5, 3); step(); idle();
    sample();
    chk("x5 busy", 64'(rd_busy[0]), 64'h1);
    chk("x5 tag", 64'(rt(0)), 64'h3);
    chk("cnt after issue", 64'(busy_cnt), 64'h1);

    step(); commit(5, 3, 32'hDEADBEEF);
    sample();
    chk("bypass val", 64'(rv(0)), 64'hDEADBEEF);
    chk("bypass busy", 64'(rd_busy[0]), 64'h0);
    chk("bypass tag", 64'(rt(0)), 64'h0);
    step(); idle();
    sample();
    chk("x5 released", 64'(rd_busy[0]), 64'h0);
    chk("x5 val", 64'(rv(0)), 64'hDEADBEEF);
    chk("cnt released", 64'(busy_cnt), 64'h0);

    step(); issue(7, 2); step(); issue(7, 6); step(); idle();
    rd(7, 0); commit(7, 2, 32'h11);
    sample();
    chk("stale no bypass val", 64'(rv(0)), 64'h0);
    chk("stale no bypass busy", 64'(rd_busy[0]), 64'h1);
    step(); idle();
    sample();
    chk("stale val", 64'(rv(0)), 64'h11);
    chk("stale busy", 64'(rd_busy[0]), 64'h1);
    chk("stale tag", 64'(rt(0)), 64'h6);
    chk("stale cnt", 64'(busy_cnt), 64'h1);

    step(); issue(9, 4); step(); idle();
    rd(7, 9); commit(9, 4, 32'h99); issue(9, 8);
    sample();
    chk("same-reg bypass", 64'(rv(1)), 64'h99);
    chk("cnt before same-reg", 64'(busy_cnt), 64'h2);
    step(); idle();
    sample();
    chk("same-reg busy", 64'(rd_busy[1]), 64'h1);
    chk("same-reg tag", 64'(rt(1)), 64'h8);
    chk("same-reg val", 64'(rv(1)), 64'h99);
    chk("same-reg cnt", 64'(busy_cnt), 64'h2);

    step(); issue(1, 1); step(); issue(2, 2); step(); issue(3, 3); step(); idle();
    sample();
    chk("cnt before flush", 64'(busy_cnt), 64'h5);
    rob_clear = 1; commit(4, 0, 32'h55); issue(6, 5);
    step(); idle(); rd(4, 5);
    sample();
    chk("flush cnt", 64'(busy_cnt), 64'h0);
    chk("flush commit val", 64'(rv(0)), 64'h55);
    chk("flush keeps val", 64'(rv(1)), 64'hDEADBEEF);
    rd(6, 9);
    sample();
    chk("flush drops issue", 64'(rd_busy[0]), 64'h0);
    chk("flush keeps x9 val", 64'(rv(1)), 64'h99);

    step(); issue(11, 9); step(); idle();
    rdy = 0; issue(10, 1); commit(11, 9, 32'h77); rd(11, 10);
    sample();
    chk("stall no bypass", 64'(rd_busy[0]), 64'h1);
    step(); rdy = 1; idle();
    sample();
    chk("stall x11 val", 64'(rv(0)), 64'h0);
    chk("stall x10 busy", 64'(rd_busy[1]), 64'h0);
    chk("stall cnt", 64'(busy_cnt), 64'h1);

    issue(0, 3); commit(0, 0, 32'hFF); rd(0, 0);
    step(); idle();
    sample();
    chk("x0 val", 64'(rv(0)), 64'h0);
    chk("x0 busy", 64'(rd_busy[0]), 64'h0);
    chk("x0 cnt", 64'(busy_cnt), 64'h1);

    issue(12, 7); step(); idle();
    rdy = 0; rob_clear = 1; step(); rdy = 1; idle();
    sample();
    chk("stalled flush cnt", 64'(busy_cnt), 64'h0);

    for (int i = 0; i < 60; i++) begin
      int r;
      idle();
      rdy = ($urandom_range(0, 4) != 0);
      rob_clear = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 1) issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1) begin
        r = int'($urandom_range(0, 7));
        commit(r, ($urandom_range(0, 3) != 0) ? int'(m_tag[r]) : int'($urandom_range(0, 15)), $urandom);
      end
      rd(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      step();
    end
    rdy = 1; idle();

    issue(9, 1); rst = 1; step(); rst = 0; idle(); rd(9, 5);
    sample();
    chk("reset x9 val", 64'(rv(0)), 64'h0);
    chk("reset x9 busy", 64'(rd_busy[0]), 64'h0);
    chk("reset x5 val again", 64'(rv(1)), 64'h0);
    chk("reset cnt again", 64'(busy_cnt), 64'h0);

    step();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
